fir_tcdm_mem: RTL and testbench
===============================

// Module: fir_tcdm_mem
// PURPOSE
//  Banked, multi-port TCDM memory that serves the MP flat TCDM master ports of the FIR accelerator wrapper.
//  Word-interleaved banks with per-bank round-robin arbitration; gnt is combinational, responses are registered.
//  Used as the shared-memory stage in standalone simulation and in FPGA builds.
//  Exports a bank-conflict counter for bandwidth analysis.
// PARAMETERS
//  MP         4      number of master ports; must equal the FIR wrapper MP
//  NB         8      number of banks, power of 2, NB >= 2
//  DEPTH      1024   32-bit words per bank, power of 2
//  STALL_THR  4      stall threshold 0..15; used only with FIR_TCDM_MEM_STALL_EN
//  LFSR_SEED  16'hACE1  nonzero LFSR reset seed; used only with FIR_TCDM_MEM_STALL_EN
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        asynchronous reset, active-low
//  tcdm_req       in   MP       request per port
//  tcdm_gnt       out  MP       grant per port, combinational from req/add/state
//  tcdm_add       in   MPx32    byte address per port
//  tcdm_wen       in   MP       1 = read, 0 = write
//  tcdm_be        in   MPx4     byte enables, used on writes only
//  tcdm_data      in   MPx32    write data
//  tcdm_r_data    out  MPx32    response data
//  tcdm_r_valid   out  MP       response valid
//  conflict_cnt_o out  32       count of denied request-cycles
// BEHAVIOUR
//  - Address decode: bank = add[2 +: log2(NB)]; row = add[2+log2(NB) +: log2(DEPTH)].
//  - add[1:0] and bits above row are ignored, so addresses alias modulo NB*DEPTH*4 bytes.
//  - Arbitration, per bank b: the candidates are the ports with req=1 whose decoded bank is b.
//  - At most one candidate per bank is granted per cycle.
//  - The winner is the first candidate at or after rr_ptr[b], searching upward mod MP.
//  - On a grant in bank b, rr_ptr[b] <= winner+1 (mod MP). Banks with no grant keep rr_ptr.
//  - Ports targeting different banks are all granted in the same cycle.
//  - Access: performed at the clock edge that ends the grant cycle.
//  - Write: update only the bytes with be[k]=1. be=0 is a legal no-op write.
//  - Response: r_valid=1 exactly one cycle after every grant, for reads and for writes.
//  - r_data is the pre-edge word for reads and 0 for writes.
//  - r_valid=0 in every cycle with no grant in the previous cycle; r_data is 0 when r_valid=0.
//  - Back-to-back grants on one port give back-to-back r_valid pulses, no bubble.
//  - Latency: grant in cycle N, r_valid/r_data in cycle N+1.
//  - A read after a write to the same word returns the new data when the read is granted at N+1 or later.
//  - Same-cycle same-word access is impossible: one grant per bank per cycle.
//  - Denied requests: the master holds req/add/wen/be/data stable until granted (master rule, not checked here).
//  - conflict_cnt_o += popcount(req & ~gnt) each cycle, saturating at 32'hFFFF_FFFF.
//  - Reset, asynchronous: rr_ptr=0, r_valid=0, r_data=0, conflict_cnt_o=0, LFSR=LFSR_SEED.
//  - Memory contents are not reset.
//  - Reset asserted mid-operation drops pending responses: r_valid stays 0 until the first post-reset grant.
//  - A write already granted before the reset edge may or may not be committed.
//  - tcdm_gnt is combinational; it is 0 during reset only because req is expected to be 0.
// CONFIGURATION
//  FIR_TCDM_MEM_STALL_EN defined:
//  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
//  - When lfsr[3:0] < STALL_THR, every gnt is forced 0 that cycle.
//  - Those denials count in conflict_cnt_o, and rr_ptr is not updated.
//  - STALL_THR=0 means no stalls.
//  FIR_TCDM_MEM_STALL_EN undefined:
//  - No LFSR; the STALL_THR and LFSR_SEED parameters are ignored.
//  - Grant depends only on arbitration.
// TESTING
//  1 Reset: hold rst_ni=0 with req=0 -> gnt=0, r_valid=0, r_data=0, conflict_cnt_o=0.
//  2 Port0 writes 32'hCAFEBABE to 0x10 with be=4'hF, then reads 0x10.
//    -> write gets r_valid with r_data=0; read gets r_data=32'hCAFEBABE one cycle after its gnt.
//  3 Write 32'h11223344 to 0x20, then write 32'hAAAAAAAA with be=4'b0010, then read 0x20 -> 32'h1122AA44.
//  4 NB=8: ports 0 and 1 both read bank 0 (0x000, 0x100) in cycle N.
//    -> cycle N: gnt=2'b01; cycle N+1: port1 granted; conflict_cnt_o=1.
//    -> same request pair repeated later -> port0 wins again because rr_ptr[0]=2 after port1's grant.
//  5 Ports 0..3 read 0x0, 0x4, 0x8, 0xC in one cycle -> all four gnt=1; all four r_valid=1 next cycle; counter unchanged.
//  6 Port0 read granted in cycle N, rst_ni=0 pulsed in cycle N+1 -> r_valid=0 from reset assertion until the first post-reset grant.

Source files
------------

// File: rtl/fir_tcdm_mem_if.sv
// Flat TCDM bus bundle between the FIR accelerator master ports and the banked memory.
// One lane per master port; the memory side uses the slave modport.
interface fir_tcdm_mem_if #(
    parameter int unsigned MP = 4
);
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] data;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/fir_tcdm_mem.sv
// Word-interleaved, multi-bank TCDM with per-bank round-robin arbitration and a conflict counter.
// Optional random grant stalls are enabled with `define FIR_TCDM_MEM_STALL_EN.
module fir_tcdm_mem #(
    parameter int unsigned MP        = 4,
    parameter int unsigned NB        = 8,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned STALL_THR = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fir_tcdm_mem_if.slave        tcdm,
    output logic [31:0]          conflict_cnt_o
);

    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned RW = $clog2(DEPTH);
    localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;

    typedef logic [PW-1:0] port_t;

    function automatic port_t wrap_add(input port_t base, input int unsigned off);
        return port_t'((32'(base) + off) % MP);
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    logic [MP-1:0][BW-1:0] bank_sel;
    logic [MP-1:0][RW-1:0] row_sel;
    logic [NB-1:0][PW-1:0] rr_ptr;
    logic [NB-1:0][PW-1:0] bank_win;
    logic [NB-1:0]         bank_hit;
    logic [NB-1:0]         bank_go;
    logic [MP-1:0]         arb_gnt;
    logic [NB-1:0][31:0]   bank_rd;
    logic                  stall;
    logic [32:0]           cnt_sum;
    logic                  unused_add;

    // Address bits [1:0] and those above the row field only alias, they never select.
    assign unused_add = ^tcdm.add;

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            bank_sel[p] = tcdm.add[p][2 +: BW];
            row_sel[p]  = tcdm.add[p][2 + BW +: RW];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        arb_gnt  = '0;
        bank_hit = '0;
        bank_win = '0;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < MP; k++) begin
                if (!bank_hit[b] && tcdm.req[wrap_add(rr_ptr[b], k)] &&
                    bank_sel[wrap_add(rr_ptr[b], k)] == BW'(b)) begin
                    bank_hit[b]                     = 1'b1;
                    bank_win[b]                     = wrap_add(rr_ptr[b], k);
                    arb_gnt[wrap_add(rr_ptr[b], k)] = 1'b1;
                end
            end
        end
    end

`ifdef FIR_TCDM_MEM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[3:0] < 4'(STALL_THR));
`else
    logic unused_cfg;

    assign stall      = 1'b0;
    assign unused_cfg = ^{STALL_THR, LFSR_SEED};
`endif

    // A stall cycle denies every port and freezes all round-robin pointers.
    assign tcdm.gnt = stall ? '0 : arb_gnt;
    assign bank_go  = stall ? '0 : bank_hit;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [31:0] mem [DEPTH];
        logic [31:0] wmask;

        assign wmask      = be_mask(tcdm.be[bank_win[b]]);
        assign bank_rd[b] = mem[row_sel[bank_win[b]]];

        // NOTE: the storage array has no reset; contents survive rst_ni and start undefined.
        always_ff @(posedge clk_i) begin
            if (bank_go[b] && !tcdm.wen[bank_win[b]]) begin
                mem[row_sel[bank_win[b]]] <= (mem[row_sel[bank_win[b]]] & ~wmask) |
                                             (tcdm.data[bank_win[b]] & wmask);
            end
        end
    end

    assign cnt_sum = {1'b0, conflict_cnt_o} + 33'($countones(tcdm.req & ~tcdm.gnt));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr         <= '0;
            tcdm.r_valid   <= '0;
            tcdm.r_data    <= '0;
            conflict_cnt_o <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_go[b]) begin
                    rr_ptr[b] <= wrap_add(bank_win[b], 1);
                end
            end
            tcdm.r_valid <= tcdm.gnt;
            for (int p = 0; p < MP; p++) begin
                tcdm.r_data[p] <= (tcdm.gnt[p] && tcdm.wen[p]) ? bank_rd[bank_sel[p]] : '0;
            end
            conflict_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

endmodule

// File: tb/tb_fir_tcdm_mem.sv
// Directed bench for fir_tcdm_mem: a flat word model and a response scoreboard predict gnt,
// r_valid, r_data and the conflict counter cycle by cycle.
module tb_fir_tcdm_mem;

    localparam int MP    = 4;
    localparam int NB    = 8;
    localparam int DEPTH = 1024;

    typedef struct {
        int          port;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] conflict_cnt;

    fir_tcdm_mem_if #(.MP(MP)) tcdm ();

    fir_tcdm_mem #(
        .MP    (MP),
        .NB    (NB),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tcdm           (tcdm),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    resp_t       sb[$];
    logic [31:0] model [int unsigned];
    logic [31:0] exp_cnt = '0;
    int          checks  = 0;
    int          errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % (NB * DEPTH);
    endfunction

    task automatic drive(input int p, input logic r, input logic [31:0] a, input logic w,
                         input logic [3:0] be, input logic [31:0] d);
        tcdm.req[p]  = r;
        tcdm.add[p]  = a;
        tcdm.wen[p]  = w;
        tcdm.be[p]   = be;
        tcdm.data[p] = d;
    endtask

    task automatic idle();
        tcdm.req = '0;
    endtask

    // One bus cycle: check grants mid-cycle, predict responses, check them after the edge.
    task automatic step(input logic [MP-1:0] exp_gnt, input string tag);
        logic [31:0] exp_d;
        logic [31:0] old;
        logic [31:0] m;
        @(negedge clk);
        check({tag, "_gnt"}, 32'(tcdm.gnt), 32'(exp_gnt));
        for (int p = 0; p < MP; p++) begin
            if (exp_gnt[p]) begin
                if (tcdm.wen[p]) begin
                    sb.push_back('{p, model[widx(tcdm.add[p])]});
                end else begin
                    old = model.exists(widx(tcdm.add[p])) ? model[widx(tcdm.add[p])] : '0;
                    m   = {{8{tcdm.be[p][3]}}, {8{tcdm.be[p][2]}}, {8{tcdm.be[p][1]}}, {8{tcdm.be[p][0]}}};
                    model[widx(tcdm.add[p])] = (old & ~m) | (tcdm.data[p] & m);
                    sb.push_back('{p, 32'h0});
                end
            end
        end
        exp_cnt = exp_cnt + 32'($countones(tcdm.req & ~exp_gnt));
        @(posedge clk);
        #1;
        check({tag, "_rvalid"}, 32'(tcdm.r_valid), 32'(exp_gnt));
        for (int p = 0; p < MP; p++) begin
            exp_d = '0;
            if (exp_gnt[p] && sb.size() != 0) exp_d = sb.pop_front().data;
            check($sformatf("%s_rdata%0d", tag, p), tcdm.r_data[p], exp_d);
        end
        check({tag, "_cnt"}, conflict_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        tcdm.req  = '0;
        tcdm.add  = '0;
        tcdm.wen  = '1;
        tcdm.be   = '0;
        tcdm.data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(tcdm.gnt), 32'h0);
        check("rst_rvalid", 32'(tcdm.r_valid), 32'h0);
        for (int p = 0; p < MP; p++) check($sformatf("rst_rdata%0d", p), tcdm.r_data[p], 32'h0);
        check("rst_cnt", conflict_cnt, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read back, back-to-back on port 0
        drive(0, 1, 32'h10, 0, 4'hF, 32'hCAFEBABE);
        step(4'b0001, "t2_wr");
        drive(0, 1, 32'h10, 1, 4'h0, 32'h0);
        step(4'b0001, "t2_rd");
        idle();

        // Preload words for the conflict and parallel tests; port 3 leaves bank 0 pointer at 0
        drive(0, 1, 32'h0, 0, 4'hF, 32'h0000_A000);
        drive(1, 1, 32'h4, 0, 4'hF, 32'h0000_A004);
        drive(2, 1, 32'h8, 0, 4'hF, 32'h0000_A008);
        drive(3, 1, 32'hC, 0, 4'hF, 32'h0000_A00C);
        step(4'b1111, "pre_par");
        idle();
        drive(3, 1, 32'h100, 0, 4'hF, 32'h0000_B100);
        step(4'b1000, "pre_100");
        idle();

        // Two ports in bank 0: port 0 first, then port 1, pointer then favours port 0 again
        drive(0, 1, 32'h000, 1, 4'h0, 32'h0);
        drive(1, 1, 32'h100, 1, 4'h0, 32'h0);
        step(4'b0001, "t4_n");
        tcdm.req[0] = 1'b0;
        step(4'b0010, "t4_n1");
        idle();
        step(4'b0000, "t4_idle");
        drive(0, 1, 32'h000, 1, 4'h0, 32'h0);
        drive(1, 1, 32'h100, 1, 4'h0, 32'h0);
        step(4'b0001, "t4_rep");
        tcdm.req[0] = 1'b0;
        step(4'b0010, "t4_rep1");
        idle();

        // Partial byte writes, be=0 no-op, address aliasing
        drive(0, 1, 32'h20, 0, 4'hF, 32'h11223344);
        step(4'b0001, "t3_wr");
        drive(0, 1, 32'h20, 0, 4'b0010, 32'hAAAAAAAA);
        step(4'b0001, "t3_wrb");
        drive(0, 1, 32'h20, 1, 4'h0, 32'h0);
        step(4'b0001, "t3_rd");
        drive(0, 1, 32'h20, 0, 4'h0, 32'hFFFFFFFF);
        step(4'b0001, "t3_be0");
        drive(0, 1, 32'h20, 1, 4'h0, 32'h0);
        step(4'b0001, "t3_rd2");
        idle();
        drive(2, 1, 32'h44, 0, 4'hF, 32'hDEADBEEF);
        step(4'b0100, "alias_wr");
        drive(2, 1, 32'h8044, 1, 4'h0, 32'h0);
        step(4'b0100, "alias_rd");
        drive(2, 1, 32'h47, 1, 4'h0, 32'h0);
        step(4'b0100, "alias_lsb");
        idle();

        // Four ports, four banks: all granted, no conflicts
        drive(0, 1, 32'h0, 1, 4'h0, 32'h0);
        drive(1, 1, 32'h4, 1, 4'h0, 32'h0);
        drive(2, 1, 32'h8, 1, 4'h0, 32'h0);
        drive(3, 1, 32'hC, 1, 4'h0, 32'h0);
        step(4'b1111, "t5_par");
        idle();

        // Three ports in bank 0 with pointer at 1: order is 1, 2, 0
        drive(0, 1, 32'h0, 1, 4'h0, 32'h0);
        drive(1, 1, 32'h100, 1, 4'h0, 32'h0);
        drive(2, 1, 32'h20, 1, 4'h0, 32'h0);
        step(4'b0010, "rr3_a");
        tcdm.req[1] = 1'b0;
        step(4'b0100, "rr3_b");
        tcdm.req[2] = 1'b0;
        step(4'b0001, "rr3_c");
        idle();

        // Reset right after a grant drops the pending response
        drive(0, 1, 32'h10, 1, 4'h0, 32'h0);
        step(4'b0001, "t6_gnt");
        idle();
        rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", 32'(tcdm.r_valid), 32'h0);
        check("t6_rst_rdata0", tcdm.r_data[0], 32'h0);
        check("t6_rst_cnt", conflict_cnt, 32'h0);
        sb.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        check("t6_rst_hold", 32'(tcdm.r_valid), 32'h0);
        rst_n = 1'b1;
        step(4'b0000, "t6_idle0");
        step(4'b0000, "t6_idle1");
        drive(0, 1, 32'h000, 1, 4'h0, 32'h0);
        drive(1, 1, 32'h100, 1, 4'h0, 32'h0);
        step(4'b0001, "t6_post");
        tcdm.req[0] = 1'b0;
        step(4'b0010, "t6_post1");
        idle();
        step(4'b0000, "t6_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
